// File: rtl/elevator_pkg.sv
// Shared types and constants for the elevator controller and its call register.
package elevator_pkg;

  localparam int unsigned FLOOR_W = 4;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MOVE = 2'd1,
    ST_DOOR = 2'd2
  } state_e;

  // Down-counter width able to hold n-1, never less than one bit.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/elevator_call_reg.sv
// Latched floor calls plus the above/below reduction against the current floor.
module elevator_call_reg
  import elevator_pkg::*;
#(
  parameter int unsigned NUM_FLOORS = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_FLOORS-1:0] call_req,
  input  logic [FLOOR_W-1:0]    cur_floor,
  input  logic                  clear_cur,
  output logic [NUM_FLOORS-1:0] pending,
  output logic                  above_c,
  output logic                  below_c
);

  logic [NUM_FLOORS-1:0] cur_mask_c;

  // The current floor's bit is forced low while its stop is being served.
  assign cur_mask_c = clear_cur ? (NUM_FLOORS'(1) << cur_floor) : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      pending <= '0;
    end else begin
      pending <= (pending | call_req) & ~cur_mask_c;
    end
  end

  always_comb begin
    above_c = 1'b0;
    below_c = 1'b0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (pending[i]) begin
        if (FLOOR_W'(i) > cur_floor) above_c = 1'b1;
        if (FLOOR_W'(i) < cur_floor) below_c = 1'b1;
      end
    end
  end

endmodule

// File: rtl/elevator_controller.sv
// SCAN-policy car controller: drives an external floor counter and times the door.
module elevator_controller
  import elevator_pkg::*;
#(
  parameter int unsigned NUM_FLOORS    = 16,
  parameter int unsigned TRAVEL_CYCLES = 4,
  parameter int unsigned DOOR_CYCLES   = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_FLOORS-1:0] call_req,
  input  logic [FLOOR_W-1:0]    cur_floor,
  output logic                  cnt_enable,
  output logic                  cnt_up_down,
  output logic                  door_open,
  output logic                  moving,
  output logic [NUM_FLOORS-1:0] pending
);

  localparam int unsigned TRAV_W = cnt_w(TRAVEL_CYCLES);
  localparam int unsigned DOOR_W = cnt_w(DOOR_CYCLES);
  localparam logic [TRAV_W-1:0]  TRAV_RELOAD = TRAV_W'(TRAVEL_CYCLES - 1);
  localparam logic [DOOR_W-1:0]  DOOR_RELOAD = DOOR_W'(DOOR_CYCLES - 1);
  localparam logic [FLOOR_W-1:0] TOP_FLOOR   = FLOOR_W'(NUM_FLOORS - 1);

  state_e              state;
  logic [TRAV_W-1:0]   travel_tmr;
  logic [DOOR_W-1:0]   door_tmr;
  logic                above_c;
  logic                below_c;
  logic                here_c;
  logic                door_go_c;
  logic                ahead_c;
  logic                behind_c;

  elevator_call_reg #(
    .NUM_FLOORS (NUM_FLOORS)
  ) u_call_reg (
    .clk       (clk),
    .reset     (reset),
    .call_req  (call_req),
    .cur_floor (cur_floor),
    .clear_cur (door_go_c || (state == ST_DOOR)),
    .pending   (pending),
    .above_c   (above_c),
    .below_c   (below_c)
  );

  // A stop is only taken once the counter has settled after a step pulse.
  assign here_c    = pending[cur_floor];
  assign door_go_c = here_c && ((state == ST_IDLE) || ((state == ST_MOVE) && !cnt_enable));
  assign ahead_c   = cnt_up_down ? above_c : below_c;
  assign behind_c  = cnt_up_down ? below_c : above_c;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      cnt_enable  <= 1'b0;
      cnt_up_down <= DIR_UP;
      door_open   <= 1'b0;
      moving      <= 1'b0;
      travel_tmr  <= '0;
      door_tmr    <= '0;
    end else begin
      cnt_enable <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (door_go_c) begin
            state     <= ST_DOOR;
            door_open <= 1'b1;
            door_tmr  <= DOOR_RELOAD;
          end else if (above_c && (cnt_up_down || !below_c)) begin
            cnt_up_down <= DIR_UP;
            state       <= ST_MOVE;
            moving      <= 1'b1;
            travel_tmr  <= TRAV_RELOAD;
          end else if (below_c) begin
            cnt_up_down <= DIR_DOWN;
            state       <= ST_MOVE;
            moving      <= 1'b1;
            travel_tmr  <= TRAV_RELOAD;
          end
        end

        ST_MOVE: begin
          if (door_go_c) begin
            state     <= ST_DOOR;
            moving    <= 1'b0;
            door_open <= 1'b1;
            door_tmr  <= DOOR_RELOAD;
          end else if (travel_tmr == '0) begin
            // Timer expiry never coincides with a pulse, so a reversal here is glitch-free.
            if (ahead_c) begin
              cnt_enable <= 1'b1;
              travel_tmr <= TRAV_RELOAD;
            end else if (behind_c) begin
              cnt_up_down <= ~cnt_up_down;
            end else begin
              state  <= ST_IDLE;
              moving <= 1'b0;
            end
          end else begin
            travel_tmr <= travel_tmr - TRAV_W'(1);
          end
        end

        ST_DOOR: begin
          if (door_tmr == '0) begin
            state     <= ST_IDLE;
            door_open <= 1'b0;
          end else begin
            door_tmr <= door_tmr - DOOR_W'(1);
          end
        end

        default: begin
          state     <= ST_IDLE;
          moving    <= 1'b0;
          door_open <= 1'b0;
        end
      endcase
    end
  end

  // The counter must never be stepped past either end of the shaft.
  step_in_range: assert property (@(posedge clk) disable iff (reset)
    cnt_enable |-> (cnt_up_down ? (cur_floor != TOP_FLOOR) : (cur_floor != '0)));

endmodule
